// File: rtl/data_ram_ctrl_pkg.sv
// Shared encodings for the data RAM controller: access sizes, FSM states, feature switches.
// No logic lives here and nothing here adds latency.
// DATA_RAM_MISALIGN_CHK_EN selects whether misaligned accesses are trapped or forced aligned.
package data_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic FEAT_EN  = 1'b1;
    localparam logic FEAT_DIS = 1'b0;

`ifdef DATA_RAM_MISALIGN_CHK_EN
    localparam logic MISALIGN_CHK = FEAT_EN;
`else
    localparam logic MISALIGN_CHK = FEAT_DIS;
`endif

    localparam int WAIT_CNT_W = 3;

    // Attributes of the accepted request, held until its response has been issued.
    typedef struct packed {
        logic  we;
        size_e size;
        logic  uns;
        logic  err;
    } req_meta_t;

    // The spare encoding 11 behaves exactly like a full-word access.
    function automatic size_e size_norm(input logic [1:0] raw);
        size_e s;
        case (raw)
            2'b00:   s = SZ_BYTE;
            2'b01:   s = SZ_HALF;
            default: s = SZ_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// Byte-lane word array: per-lane write strobe, registered read port.
// Write and read both take effect on the clock edge; read data appears one edge later.
// No backpressure; the caller issues at most one access per cycle.
module data_ram_bank
    import data_ram_ctrl_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int NB     = DATA_W / 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic              rd_en_i,
    input  logic [NB-1:0]     wr_strb_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (wr_strb_i[k]) begin
                mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Load/store front end for a little-endian byte-addressed RAM (DATA_RAM_MISALIGN_CHK_EN traps misalignment).
// Response 1+WAIT cycles after acceptance; rsp_valid is a single-cycle pulse.
// req_ready drops while a request waits out its extra cycles or while ce is low.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    parameter  int WAIT   = 0,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB),
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int ADDR_W = IDX_W + OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LD =
        (WAIT > 0) ? WAIT_CNT_W'(WAIT - 1) : '0;

    state_e                 st_q, st_d;
    logic [WAIT_CNT_W-1:0]  wcnt_q, wcnt_d;
    req_meta_t              meta_q, meta_d;
    logic [OFF_W-1:0]       off_q, off_d;

    logic                   accept;
    size_e                  req_sz;
    logic                   is_half, is_word;
    logic [OFF_W-1:0]       raw_off, acc_off;
    logic                   misalign;
    logic [NB-1:0]          lane_mask, wr_strb;
    logic [DATA_W-1:0]      lane_wdata;
    logic [DATA_W-1:0]      bank_rdata, shifted, ext;

    assign req_ready = ce & ((st_q == ST_IDLE) | (st_q == ST_RESP));
    assign accept    = req_valid & req_ready;

    assign req_sz  = size_norm(req_size);
    assign is_half = (req_sz == SZ_HALF);
    assign is_word = (req_sz == SZ_WORD);
    assign raw_off = req_addr[OFF_W-1:0];

    assign misalign = MISALIGN_CHK & ((is_half & raw_off[0]) | (is_word & (|raw_off)));

    // Sub-size address bits are dropped so that every access lands on its natural boundary.
    always_comb begin
        acc_off    = raw_off;
        lane_mask  = NB'(1) << raw_off;
        lane_wdata = {NB{req_wdata[7:0]}};
        if (is_word) begin
            acc_off    = '0;
            lane_mask  = '1;
            lane_wdata = req_wdata;
        end else if (is_half) begin
            acc_off    = {raw_off[OFF_W-1:1], 1'b0};
            lane_mask  = NB'(3) << {raw_off[OFF_W-1:1], 1'b0};
            lane_wdata = {(NB/2){req_wdata[15:0]}};
        end
    end

    assign wr_strb = (accept & req_we & ~misalign) ? lane_mask : '0;

    data_ram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst),
        .addr_i    (req_addr[ADDR_W-1:OFF_W]),
        .rd_en_i   (accept & ~req_we),
        .wr_strb_i (wr_strb),
        .wdata_i   (lane_wdata),
        .rdata_o   (bank_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            wcnt_q <= '0;
            meta_q <= '0;
            off_q  <= '0;
        end else begin
            st_q   <= st_d;
            wcnt_q <= wcnt_d;
            meta_q <= meta_d;
            off_q  <= off_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        wcnt_d = wcnt_q;
        meta_d = meta_q;
        off_d  = off_q;
        if (accept) begin
            meta_d.we   = req_we;
            meta_d.size = req_sz;
            meta_d.uns  = req_unsigned;
            meta_d.err  = misalign;
            off_d       = acc_off;
            wcnt_d      = WAIT_LD;
        end
        case (st_q)
            ST_IDLE: begin
                if (accept) st_d = (WAIT == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) st_d = ST_RESP;
                else              wcnt_d = wcnt_q - 1'b1;
            end
            ST_RESP: begin
                if (accept) st_d = (WAIT == 0) ? ST_RESP : ST_WAIT;
                else        st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign shifted = bank_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = shifted;
        case (meta_q.size)
            SZ_BYTE: ext = {{(DATA_W-8){~meta_q.uns & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext = {{(DATA_W-16){~meta_q.uns & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign rsp_valid = (st_q == ST_RESP);
    assign rsp_rdata = (rsp_valid & ~meta_q.we & ~meta_q.err) ? ext : '0;
    assign rsp_err   = MISALIGN_CHK & rsp_valid & meta_q.err;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: two instances (WAIT=0 and WAIT=3) against a byte-array reference model.
module tb_data_ram_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int NB     = DATA_W / 8;
    localparam int ADDR_W = $clog2(DEPTH) + $clog2(NB);
    localparam int NBYTES = DEPTH * NB;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic              ce [2];
    logic              req_valid [2];
    logic              req_ready [2];
    logic              req_we [2];
    logic [ADDR_W-1:0] req_addr [2];
    logic [1:0]        req_size [2];
    logic              req_unsigned [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic              rsp_valid [2];
    logic [DATA_W-1:0] rsp_rdata [2];
    logic              rsp_err [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    data_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT(3)) dut1 (
        .clk(clk), .rst(rst), .ce(ce[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    // ---------------- reference model ----------------
    logic [7:0]        mem_m [2][NBYTES];
    bit                pend [2] = '{0, 0};
    longint unsigned   resp_cyc [2];
    logic [DATA_W-1:0] exp_dat [2];
    bit                exp_err [2];
    longint unsigned   cyc = 0;

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic bit model_ready(input int i);
        return ce[i] && !(pend[i] && cyc < resp_cyc[i]);
    endfunction

    task automatic check(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic apply(input int i);
        int n, a, base;
        bit mis;
        longint unsigned v;
        n = (req_size[i] == 2'b00) ? 1 : (req_size[i] == 2'b01) ? 2 : NB;
        a = int'(req_addr[i]);
        mis = (a % n) != 0;
`ifdef DATA_RAM_MISALIGN_CHK_EN
        exp_err[i] = mis;
`else
        exp_err[i] = 1'b0;
`endif
        base = a - (a % n);
        exp_dat[i] = '0;
        if (!exp_err[i]) begin
            if (req_we[i]) begin
                for (int k = 0; k < n; k++) mem_m[i][base + k] = req_wdata[i][8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (longint'(mem_m[i][base + k]) << (8 * k));
                if (!req_unsigned[i] && n < NB && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
                exp_dat[i] = v[DATA_W-1:0];
            end
        end
        pend[i] = 1'b1;
        resp_cyc[i] = cyc + 1 + longint'(wait_of(i));
    endtask

    always @(negedge rst) begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    end

    always @(posedge clk) begin
        bit acc;
        if (!rst) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc = req_valid[i] && model_ready(i);
                if (pend[i] && cyc >= resp_cyc[i]) pend[i] = 1'b0;
                if (acc) apply(i);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        for (int i = 0; i < 2; i++) begin
            ev = rst && pend[i] && (cyc == resp_cyc[i]);
            check("req_ready", i, 64'(req_ready[i]), 64'(model_ready(i)));
            check("rsp_valid", i, 64'(rsp_valid[i]), 64'(ev));
            if (ev) begin
                check("rsp_rdata", i, 64'(rsp_rdata[i]), 64'(exp_dat[i]));
                check("rsp_err", i, 64'(rsp_err[i]), 64'(exp_err[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int i, input bit we, input int addr, input logic [1:0] sz,
                        input bit uns, input logic [DATA_W-1:0] wd);
        int t;
        t = 0;
        ce[i] = 1'b1;
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i] = addr[ADDR_W-1:0];
        req_size[i] = sz;
        req_unsigned[i] = uns;
        req_wdata[i] = wd;
        @(negedge clk);
        while (!req_ready[i] && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout dut%0d: got no req_ready expected req_ready within 50 cycles", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output logic [DATA_W-1:0] d, output logic e,
                            output int lat, output int rdy_low);
        lat = 0;
        rdy_low = 0;
        d = '0;
        e = 1'b0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[i]) begin
                d = rsp_rdata[i];
                e = rsp_err[i];
                break;
            end
            if (!req_ready[i]) rdy_low++;
        end
        if (lat >= 50) begin
            n_chk++;
            n_err++;
            $display("FAIL rsp_timeout dut%0d: got no rsp_valid expected rsp_valid within 50 cycles", i);
        end
    endtask

    task automatic access(input int i, input bit we, input int addr, input logic [1:0] sz,
                          input bit uns, input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] d,
                          output logic e);
        int lat, rl;
        send(i, we, addr, sz, uns, wd);
        wait_rsp(i, d, e, lat, rl);
    endtask

    task automatic rand_phase(input int i, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            ce[i]           = ($urandom_range(0, 9) != 0);
            req_valid[i]    = ($urandom_range(0, 9) < 7);
            req_we[i]       = $urandom_range(0, 1) == 1;
            req_addr[i]     = ADDR_W'($urandom_range(0, NBYTES - 1));
            req_size[i]     = 2'($urandom_range(0, 3));
            req_unsigned[i] = $urandom_range(0, 1) == 1;
            req_wdata[i]    = $urandom;
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DATA_W-1:0] d;
        logic e;
        int lat, rl, cnt_rdy, cnt_v;

        for (int i = 0; i < 2; i++) begin
            ce[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_size[i] = 2'b00; req_unsigned[i] = 1'b0; req_wdata[i] = '0;
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            check("reset_rsp_valid", i, 64'(rsp_valid[i]), 64'd0);
            check("reset_rsp_rdata", i, 64'(rsp_rdata[i]), 64'd0);
            check("reset_rsp_err", i, 64'(rsp_err[i]), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        fork
            for (int w = 0; w < DEPTH; w++) access(0, 1'b1, w * NB, 2'b10, 1'b0, $urandom, d, e);
            begin
                logic [DATA_W-1:0] d1;
                logic e1;
                for (int w = 0; w < DEPTH; w++) access(1, 1'b1, w * NB, 2'b10, 1'b0, $urandom, d1, e1);
            end
        join

        // word store then unsigned byte load from the middle of it
        access(0, 1'b1, 'h10, 2'b10, 1'b0, 32'h8765_4321, d, e);
        check("store_rdata_zero", 0, 64'(d), 64'd0);
        send(0, 1'b0, 'h11, 2'b00, 1'b1, '0);
        wait_rsp(0, d, e, lat, rl);
        check("lbu_0x11", 0, 64'(d), 64'h43);
        check("lat_wait0", 0, 64'(lat), 64'd1);

        access(0, 1'b1, 'h22, 2'b00, 1'b0, 32'hFFFF_FFF0, d, e);
        access(0, 1'b1, 'h23, 2'b00, 1'b0, 32'h0000_0000, d, e);
        access(0, 1'b0, 'h22, 2'b00, 1'b0, '0, d, e);
        check("lb_signed_0x22", 0, 64'(d), 64'hFFFF_FFF0);
        access(0, 1'b0, 'h22, 2'b01, 1'b1, '0, d, e);
        check("lhu_0x22", 0, 64'(d), 64'h0000_00F0);

`ifdef DATA_RAM_MISALIGN_CHK_EN
        access(0, 1'b1, 'h13, 2'b10, 1'b0, 32'hDEAD_BEEF, d, e);
        check("misalign_err", 0, 64'(e), 64'd1);
        access(0, 1'b0, 'h10, 2'b10, 1'b0, '0, d, e);
        check("misalign_no_write", 0, 64'(d), 64'h8765_4321);
`else
        access(0, 1'b0, 'h13, 2'b01, 1'b1, '0, d, e);
        check("forced_align_half", 0, 64'(d), 64'h0000_8765);
        check("forced_align_err", 0, 64'(e), 64'd0);
`endif

        // WAIT=3 latency and ready gap
        access(1, 1'b1, 'h10, 2'b10, 1'b0, 32'h1122_3344, d, e);
        send(1, 1'b0, 'h10, 2'b10, 1'b0, '0);
        wait_rsp(1, d, e, lat, rl);
        check("lat_wait3", 1, 64'(lat), 64'd4);
        check("ready_low_cycles", 1, 64'(rl), 64'd3);
        check("lw_wait3", 1, 64'(d), 64'h1122_3344);

        // reset while a request is waiting
        send(1, 1'b0, 'h10, 2'b10, 1'b0, '0);
        rst = 1'b0;
        #1;
        check("rst_abort_valid", 1, 64'(rsp_valid[1]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt_v = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid[1]) cnt_v++;
        end
        check("no_rsp_after_rst", 1, 64'(cnt_v), 64'd0);
        access(1, 1'b0, 'h10, 2'b10, 1'b0, '0, d, e);
        check("mem_kept_after_rst", 1, 64'(d), 64'h1122_3344);
        access(0, 1'b0, 'h11, 2'b00, 1'b1, '0, d, e);
        check("mem_kept_after_rst", 0, 64'(d), 64'h43);

        // back-to-back loads on the zero-wait instance
        @(posedge clk);
        #1;
        cnt_rdy = 0;
        cnt_v = 0;
        for (int k = 0; k < 8; k++) begin
            ce[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'b10;
            req_addr[0] = ADDR_W'(k * NB);
            @(negedge clk);
            if (req_ready[0]) cnt_rdy++;
            if (k > 0 && rsp_valid[0]) cnt_v++;
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        if (rsp_valid[0]) cnt_v++;
        check("b2b_ready", 0, 64'(cnt_rdy), 64'd8);
        check("b2b_rsp_count", 0, 64'(cnt_v), 64'd8);

        fork
            rand_phase(0, 1500);
            rand_phase(1, 1500);
        join
        repeat (10) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data word width in bits (multiple of 8, value 32 or 64).
REQ-002 Parameter DEPTH, default 1024, SHALL set the number of words (power of 2).
REQ-003 Parameter WAIT, default 0, SHALL set extra wait cycles per access (0..7).
REQ-004 Derived constant ADDR_W SHALL equal log2(DEPTH)+log2(DATA_W/8) and is the byte-address width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the reset, asynchronous, active-low.
REQ-007 ce  in  1  SHALL be chip enable; low blocks new requests.
REQ-008 req_valid  in  1  SHALL flag a request.
REQ-009 req_ready  out  1  SHALL flag that the block accepts a request this cycle.
REQ-010 req_we  in  1  SHALL select store (1) or load (0).
REQ-011 req_addr  in  ADDR_W  SHALL be the byte address.
REQ-012 req_size  in  2  SHALL encode 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-013 req_unsigned  in  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-014 req_wdata  in  DATA_W  SHALL carry store data, right-aligned.
REQ-015 rsp_valid  out  1  SHALL pulse for one cycle per completed request.
REQ-016 rsp_rdata  out  DATA_W  SHALL carry the extended load result.
REQ-017 rsp_err  out  1  SHALL flag a misaligned request, valid with rsp_valid.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid, req_ready and ce are all 1.
REQ-019 FSM states SHALL be IDLE, WAIT, RESP; IDLE->RESP on accept when WAIT=0, IDLE->WAIT on accept when WAIT>0, WAIT->RESP when the wait counter reaches 0, RESP->WAIT or RESP on accept, RESP->IDLE otherwise.
REQ-020 req_ready SHALL be ce AND (state is IDLE or RESP).
REQ-021 rsp_valid SHALL be 1 exactly in RESP, giving response latency 1+WAIT cycles after acceptance.
REQ-022 A 3-bit wait counter SHALL load WAIT-1 on accept and decrement by 1 each WAIT-state cycle.
REQ-023 Storage SHALL be little-endian: byte lane k of a word holds byte address (word_index*DATA_W/8 + k).
REQ-024 A store SHALL update only the addressed byte lanes, on the accepting edge, using the low 8/16/DATA_W bits of req_wdata.
REQ-025 A load SHALL read the array on the accepting edge into a result register, so a load accepted after a store to the same address returns the new data.
REQ-026 A load result SHALL be the addressed byte/half/word shifted to bit 0, then sign- or zero-extended per req_unsigned; word loads are not extended.
REQ-027 A store response SHALL drive rsp_rdata to 0.
REQ-028 Deasserting ce while a request is in flight SHALL NOT abort it; its response SHALL still be issued.
REQ-029 Addresses SHALL wrap modulo DEPTH words; no out-of-range error.

Reset
REQ-030 Asserting rst SHALL immediately force state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, and abort any in-flight response.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With DATA_RAM_MISALIGN_CHK_EN defined, a half access with addr[0]=1 or a word access with any low address bit set SHALL not write, SHALL return rsp_rdata 0, and SHALL assert rsp_err with its rsp_valid.
REQ-033 Without DATA_RAM_MISALIGN_CHK_EN, the low address bits below the access size SHALL be ignored (forced aligned) and rsp_err SHALL be tied 0.

Structure
REQ-034 Size encodings, FSM state encodings and the enable/disable constants SHALL live in the shared defs package.
REQ-035 The byte-lane array SHALL be one sub-module, data_ram_bank, with a per-lane write strobe and a registered read; data_ram_ctrl holds the FSM, alignment and extension logic.

Verification
REQ-036 Store word 0x8765_4321 to 0x10, then load byte unsigned at 0x11 -> rsp_rdata 0x0000_0043.
REQ-037 Store byte 0xF0 to 0x22, then load byte signed at 0x22 -> 0xFFFF_FFF0; load half unsigned at 0x22 -> 0x0000_00F0 when byte 0x23 is 0.
REQ-038 With WAIT=3, request accepted at cycle 10 -> rsp_valid only in cycle 14; req_ready low in cycles 11-13.
REQ-039 With DATA_RAM_MISALIGN_CHK_EN, store word to 0x13 -> rsp_err 1, memory at 0x10 unchanged on read-back.
REQ-040 rst low during WAIT state -> rsp_valid 0 next cycle, no response afterwards, prior memory data retained.
REQ-041 WAIT=0, back-to-back loads on consecutive cycles -> one rsp_valid per cycle with matching data, req_ready held 1.
